// File: rtl/conv1d_mac_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv1d_mac_sequencer: streams kernel taps through the shared multiplier  |
// | and accumulates one conv1d psum.   Revision: 1.0                         |
// +--------------------------------------------------------------------------+
module conv1d_mac_sequencer #(
  parameter int WIDTH_DATA = 16,
  parameter int KERNEL_MAX = 16,
  parameter int ADDR_W     = 4,
  parameter int LEN_W      = 5,
  parameter int ACC_W      = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        kernel_len_i,
  input  logic [ACC_W-1:0]        psum_in_i,
  output logic                    busy_o,
  output logic                    buf_rd_en_o,
  output logic [ADDR_W-1:0]       buf_rd_addr_o,
  input  logic [WIDTH_DATA-1:0]   weight_rd_data_i,
  input  logic [WIDTH_DATA-1:0]   feature_rd_data_i,
  output logic [WIDTH_DATA-1:0]   mul_weight_o,
  output logic [WIDTH_DATA-1:0]   mul_feature_o,
  input  logic [2*WIDTH_DATA-1:0] mul_result_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ACC_W-1:0]        out_data_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] KMAX = LEN_W'(KERNEL_MAX);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    tap_vld_q, tap_vld_d;
  logic [WIDTH_DATA-1:0]   mul_weight_q, mul_weight_d;
  logic [WIDTH_DATA-1:0]   mul_feature_q, mul_feature_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic [LEN_W-1:0]        eff_len;
  logic [ACC_W-1:0]        prod_ext;

  assign eff_len  = (kernel_len_i > KMAX) ? KMAX : kernel_len_i;
  assign prod_ext = {{(ACC_W-2*WIDTH_DATA){mul_result_i[2*WIDTH_DATA-1]}}, mul_result_i};

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    mul_weight_d  = mul_weight_q;
    mul_feature_d = mul_feature_q;
    acc_d         = acc_q;
    out_data_d    = out_data_q;
    // Read data lands one cycle after the strobe; operands capture it the cycle after that.
    rd_pend_d     = (state_q == S_RUN);
    tap_vld_d     = rd_pend_q;
    if (rd_pend_q) begin
      mul_weight_d  = weight_rd_data_i;
      mul_feature_d = feature_rd_data_i;
    end
    if (tap_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d = eff_len;
          cnt_d = '0;
          acc_d = psum_in_i;
          if (eff_len == '0) begin
            out_data_d = psum_in_i;
            state_d    = S_OUT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        // Second drain cycle retires the last tap; publish the sum including it.
        if (cnt_q == LEN_W'(1)) begin
          cnt_d      = '0;
          out_data_d = acc_d;
          state_d    = S_OUT;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      rd_pend_q     <= 1'b0;
      tap_vld_q     <= 1'b0;
      mul_weight_q  <= '0;
      mul_feature_q <= '0;
      acc_q         <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      tap_vld_q     <= tap_vld_d;
      mul_weight_q  <= mul_weight_d;
      mul_feature_q <= mul_feature_d;
      acc_q         <= acc_d;
      out_data_q    <= out_data_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign buf_rd_en_o   = (state_q == S_RUN);
  assign buf_rd_addr_o = cnt_q[ADDR_W-1:0];
  assign mul_weight_o  = mul_weight_q;
  assign mul_feature_o = mul_feature_q;
  assign out_valid_o   = (state_q == S_OUT);
  assign out_data_o    = out_data_q;

endmodule
`default_nettype wire
